// File: rtl/hd_rr_arbiter_if.sv
// Bundle of the upstream request channels and the downstream handshake.
// The arbiter takes the slave view. The requesters/sink take the master view.
interface hd_rr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4,
    parameter int ID_WIDTH   = 2
);
    logic [N_REQ-1:0]            valid;
    logic [N_REQ-1:0]            last;
    logic [N_REQ*DATA_WIDTH-1:0] data_src;
    logic [N_REQ-1:0]            ready_output;
    logic                        valid_output;
    logic [DATA_WIDTH-1:0]       data_dest;
    logic                        last_output;
    logic [ID_WIDTH-1:0]         src_id;
    logic                        ready;

    modport master (
        output valid, last, data_src, ready,
        input  ready_output, valid_output, data_dest, last_output, src_id
    );

    modport slave (
        input  valid, last, data_src, ready,
        output ready_output, valid_output, data_dest, last_output, src_id
    );
endinterface

// File: rtl/hd_rr_arbiter.sv
// Packet-atomic round-robin arbiter feeding one registered valid/ready output stage.
// A winner keeps the channel until it transfers a beat with last=1.
module hd_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic           clk,
    input  logic           rst,
    hd_rr_arbiter_if.slave bus
);
    logic                  valid_q,   valid_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic                  last_q,    last_d;
    logic [ID_WIDTH-1:0]   src_q,     src_d;
    logic [ID_WIDTH-1:0]   ptr_q,     ptr_d;
    logic                  locked_q,  locked_d;
    logic [ID_WIDTH-1:0]   lock_id_q, lock_id_d;

    logic                  load;
    logic [N_REQ-1:0]      eligible;
    logic                  found;
    logic [ID_WIDTH-1:0]   win;
    logic [N_REQ-1:0]      grant;
    logic                  accept;

    assign load   = !valid_q || bus.ready;
    assign accept = load && found;

    // Rotating search starting at ptr_q; mid-packet only the lock owner may compete.
    always_comb begin : select_winner
        int idx;
        eligible = bus.valid;
        if (locked_q) begin
            eligible = bus.valid & (N_REQ'(1) << lock_id_q);
        end
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin : grant_decode
        grant = '0;
        if (accept) begin
            grant[win] = 1'b1;
        end
    end

    // NOTE: the grant is masked by rst so no requester sees ready while the stage is held in reset.
    assign bus.ready_output = grant & {N_REQ{rst}};

    always_comb begin : next_state
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        src_d     = src_q;
        ptr_d     = ptr_q;
        locked_d  = locked_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = bus.data_src[win*DATA_WIDTH +: DATA_WIDTH];
            last_d  = bus.last[win];
            src_d   = win;
            if (bus.last[win]) begin
                locked_d = 1'b0;
                ptr_d    = (win == ID_WIDTH'(N_REQ - 1)) ? '0 : win + ID_WIDTH'(1);
            end else begin
                locked_d  = 1'b1;
                lock_id_d = win;
            end
        end else if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            src_q     <= '0;
            ptr_q     <= '0;
            locked_q  <= 1'b0;
            lock_id_q <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
            src_q     <= src_d;
            ptr_q     <= ptr_d;
            locked_q  <= locked_d;
            lock_id_q <= lock_id_d;
        end
    end

    assign bus.valid_output = valid_q;
    assign bus.data_dest    = data_q;
    assign bus.last_output  = last_q;
    assign bus.src_id       = src_q;
endmodule

// File: tb/tb_hd_rr_arbiter.sv
// Scoreboard bench for hd_rr_arbiter: expected beats are queued by each scenario
// and retired by a monitor whenever a downstream transfer is visible.
module tb_hd_rr_arbiter;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] src;
        logic          last;
    } beat_t;

    logic clk;
    logic rst;

    hd_rr_arbiter_if #(.DATA_WIDTH(DW), .N_REQ(NR), .ID_WIDTH(IW)) bus ();

    hd_rr_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR), .ID_WIDTH(IW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t         sb[$];
    beat_t         exp_b;
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [NR-1:0] exp_grant;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "timeout");
    end

    // Retires one expected beat per visible downstream transfer.
    always @(negedge clk) begin
        if (rst && bus.valid_output && bus.ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got data=%h src=%0d last=%b, required no beat",
                         bus.data_dest, bus.src_id, bus.last_output);
            end else begin
                exp_b = sb.pop_front();
                if (bus.data_dest !== exp_b.data || bus.src_id !== exp_b.src ||
                    bus.last_output !== exp_b.last)
                    $display("FAIL sb_beat: got data=%h src=%0d last=%b, required data=%h src=%0d last=%b",
                             bus.data_dest, bus.src_id, bus.last_output,
                             exp_b.data, exp_b.src, exp_b.last);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [DW-1:0] d);
        bus.valid[i]             = v;
        bus.last[i]              = l;
        bus.data_src[i*DW +: DW] = d;
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic [IW-1:0] s, input logic l);
        beat_t b;
        b.data = d;
        b.src  = s;
        b.last = l;
        sb.push_back(b);
    endtask

    task automatic apply_reset();
        rst          = 1'b0;
        bus.valid    = '0;
        bus.last     = '0;
        bus.data_src = '0;
        bus.ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check_grant(input string tag, input logic [NR-1:0] req);
        n_checks++;
        if (bus.ready_output !== req)
            $display("FAIL %s: ready_output=%b, required %b", tag, bus.ready_output, req);
        else n_pass++;
    endtask

    task automatic check_vout(input string tag, input logic req);
        n_checks++;
        if (bus.valid_output !== req)
            $display("FAIL %s: valid_output=%b, required %b", tag, bus.valid_output, req);
        else n_pass++;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.valid_output !== 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (sb.size() != 0 || bus.valid_output !== 1'b0)
            $display("FAIL %s_drain: %0d beats pending valid_output=%b, required 0 pending and 0",
                     tag, sb.size(), bus.valid_output);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        bus.ready = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 32'h10 + i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vout("reset_valid_output", 1'b0);
        n_checks++;
        if (bus.data_dest !== 32'h0) $display("FAIL reset_data_dest: %h, required 0", bus.data_dest);
        else n_pass++;
        n_checks++;
        if (bus.src_id !== 2'd0) $display("FAIL reset_src_id: %0d, required 0", bus.src_id);
        else n_pass++;
        n_checks++;
        if (bus.last_output !== 1'b0) $display("FAIL reset_last_output: %b, required 0", bus.last_output);
        else n_pass++;
        check_grant("reset_ready_output", 4'b0000);
        tick();
        push_beat(32'h10, 2'd0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_grant("reset_first_grant", 4'b0001);
        tick();
        bus.valid = '0;
        wait_drain("reset");
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 32'h10 + i);
        for (int c = 0; c < 5; c++) push_beat(32'h10 + (c % NR), IW'(c % NR), 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp_grant = 4'b0001 << (c % NR);
            check_grant("rr_grant", exp_grant);
            if (c > 0) check_vout("rr_valid_output", 1'b1);
            tick();
        end
        bus.valid = '0;
        wait_drain("rr");
    endtask

    task automatic test_packet_lock();
        apply_reset();
        set_req(1, 1'b1, 1'b1, 32'h11);
        push_beat(32'h11, 2'd1, 1'b1);
        @(negedge clk);
        check_grant("pkt_pre_grant", 4'b0010);
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0);
        set_req(0, 1'b1, 1'b1, 32'h20);
        set_req(3, 1'b1, 1'b1, 32'h30);
        for (int b = 0; b < 3; b++) begin
            set_req(2, 1'b1, (b == 2), 32'hA0 + b);
            push_beat(32'hA0 + b, 2'd2, (b == 2));
            @(negedge clk);
            check_grant("pkt_locked_grant", 4'b0100);
            tick();
        end
        set_req(2, 1'b0, 1'b0, 32'h0);
        push_beat(32'h30, 2'd3, 1'b1);
        push_beat(32'h20, 2'd0, 1'b1);
        @(negedge clk);
        check_grant("pkt_next_grant", 4'b1000);
        tick();
        set_req(3, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_grant("pkt_after_grant", 4'b0001);
        tick();
        bus.valid = '0;
        wait_drain("pkt");
    endtask

    task automatic test_stall();
        apply_reset();
        bus.ready = 1'b0;
        set_req(1, 1'b1, 1'b1, 32'h55);
        push_beat(32'h55, 2'd1, 1'b1);
        push_beat(32'h66, 2'd2, 1'b1);
        @(negedge clk);
        check_grant("stall_first_grant", 4'b0010);
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0);
        set_req(2, 1'b1, 1'b1, 32'h66);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            n_checks++;
            if (bus.data_dest !== 32'h55) $display("FAIL stall_data: %h, required 55", bus.data_dest);
            else n_pass++;
            check_vout("stall_valid_output", 1'b1);
            check_grant("stall_grant", 4'b0000);
            tick();
        end
        bus.ready = 1'b1;
        @(negedge clk);
        check_grant("stall_release_grant", 4'b0100);
        tick();
        bus.valid = '0;
        @(negedge clk);
        check_vout("stall_zero_bubble_valid", 1'b1);
        n_checks++;
        if (bus.data_dest !== 32'h66) $display("FAIL stall_zero_bubble_data: %h, required 66", bus.data_dest);
        else n_pass++;
        wait_drain("stall");
    endtask

    task automatic test_lock_idle();
        apply_reset();
        set_req(1, 1'b1, 1'b0, 32'hB0);
        push_beat(32'hB0, 2'd1, 1'b0);
        @(negedge clk);
        check_grant("idle_lock_grant", 4'b0010);
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0);
        set_req(0, 1'b1, 1'b1, 32'h40);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_grant("idle_grant", 4'b0000);
            check_vout("idle_valid_output", (c == 0));
            tick();
        end
        set_req(1, 1'b1, 1'b1, 32'hB1);
        push_beat(32'hB1, 2'd1, 1'b1);
        push_beat(32'h40, 2'd0, 1'b1);
        @(negedge clk);
        check_grant("idle_resume_grant", 4'b0010);
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_grant("idle_handover_grant", 4'b0001);
        tick();
        bus.valid = '0;
        wait_drain("idle");
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        bus.ready = 1'b0;
        set_req(2, 1'b1, 1'b0, 32'hC0);
        @(negedge clk);
        check_grant("midrst_lock_grant", 4'b0100);
        tick();
        set_req(0, 1'b1, 1'b1, 32'h50);
        @(negedge clk);
        check_vout("midrst_pre_valid", 1'b1);
        check_grant("midrst_pre_grant", 4'b0000);
        #2;
        rst = 1'b0;
        #1;
        check_vout("midrst_async_valid", 1'b0);
        n_checks++;
        if (bus.data_dest !== 32'h0 || bus.src_id !== 2'd0 || bus.last_output !== 1'b0)
            $display("FAIL midrst_async_regs: data=%h src=%0d last=%b, required 0 0 0",
                     bus.data_dest, bus.src_id, bus.last_output);
        else n_pass++;
        check_grant("midrst_async_grant", 4'b0000);
        tick();
        push_beat(32'h50, 2'd0, 1'b1);
        bus.ready = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        check_vout("midrst_release_valid", 1'b0);
        check_grant("midrst_restart_grant", 4'b0001);
        tick();
        bus.valid = '0;
        wait_drain("midrst");
    endtask

    initial begin
        rst          = 1'b0;
        bus.valid    = '0;
        bus.last     = '0;
        bus.data_src = '0;
        bus.ready    = 1'b1;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_stall();
        test_lock_idle();
        test_reset_mid_packet();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
